// File: rtl/fft_seq_pkg.sv
// Shared types and default sizing for the FFT frame sequencer.
package fft_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 12;
    localparam int unsigned DEF_N_POINTS   = 8192;
    localparam int unsigned DEF_CNT_W      = 13;
    localparam int unsigned STAT_W         = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } seq_state_e;

    // Saturating increment for the drop statistics counter.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fft_seq_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Push and pop may occur in the same cycle, including when full; flush empties it.
module fft_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_nxt_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // Head register is refilled from the incoming word or the next stored entry.
    always_comb begin
        do_push = push_i && (!full_q || pop_i);
        do_pop  = pop_i && !empty_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
            if (do_push && (empty_q || (do_pop && cnt_q == CW'(1)))) begin
                dout_d = din_i;
            end else if (do_pop && cnt_q > CW'(1)) begin
                dout_d = mem_q[rd_d];
            end
        end
        empty_nxt_c = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign dout_o = dout_q;
    assign full_o = full_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames the corrected ADC sample stream into N_POINTS-beat Avalon-ST packets.
// Define FFT_SEQ_STATS_EN to build the frame_count/drop_count statistics counters.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned N_POINTS   = DEF_N_POINTS,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  continuous,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic                  smp_valid,
    input  logic                  sink_ready,
    output logic                  sink_valid,
    output logic                  sink_sop,
    output logic                  sink_eop,
    output logic [DATA_WIDTH-1:0] sink_real,
    output logic [DATA_WIDTH-1:0] sink_imag,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow,
    input  logic                  clear_status,
    output logic [STAT_W-1:0]     frame_count,
    output logic [STAT_W-1:0]     drop_count
);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic             busy_q, busy_d, done_q, ovf_q, ovf_d;
    logic             accept, eop_acc, in_stream, push, drop;
    logic             fifo_full, fifo_empty_nxt;

    assign accept    = valid_q && sink_ready;
    assign eop_acc   = accept && eop_q;
    assign in_stream = (state_q == STREAM);
    assign push      = in_stream && smp_valid && (!fifo_full || accept);
    assign drop      = in_stream && smp_valid && fifo_full && !accept;

    // Leftover samples are flushed at eop so the next frame starts on fresh data.
    fft_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (eop_acc),
        .push_i      (push),
        .pop_i       (accept),
        .din_i       (smp_data),
        .dout_o      (sink_real),
        .full_o      (fifo_full),
        .empty_nxt_c (fifo_empty_nxt)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = '0;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (enable && (start || continuous)) state_d = STREAM;
            end
            STREAM: begin
                if (eop_acc) state_d = GAP;
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = (enable && continuous) ? STREAM : IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) beat_d = eop_q ? '0 : beat_q + CNT_W'(1);
        // Sink flags are registered from next-cycle state and FIFO occupancy.
        valid_d = (state_d == STREAM) && !fifo_empty_nxt;
        sop_d   = valid_d && (beat_d == '0);
        eop_d   = valid_d && (beat_d == CNT_W'(N_POINTS - 1));
        busy_d  = (state_d != IDLE);
        ovf_d   = drop ? 1'b1 : (clear_status ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            busy_q  <= busy_d;
            done_q  <= eop_acc;
            ovf_q   <= ovf_d;
        end
    end

    assign sink_valid = valid_q;
    assign sink_sop   = sop_q;
    assign sink_eop   = eop_q;
    assign sink_imag  = '0;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;

`ifdef FFT_SEQ_STATS_EN
    logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

    // A clear coinciding with an event still counts that event.
    always_comb begin
        frame_cnt_d = clear_status ? '0 : frame_cnt_q;
        drop_cnt_d  = clear_status ? '0 : drop_cnt_q;
        if (eop_acc) frame_cnt_d = frame_cnt_d + STAT_W'(1);
        if (drop)    drop_cnt_d  = sat_inc(drop_cnt_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: queue-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;
    localparam int unsigned DW = 12, NP = 16, CW = 4, DEPTH = 4, GAP = 4;
`ifdef FFT_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, enable, continuous, start, smp_valid, sink_ready, clear_status;
    logic [DW-1:0] smp_data;
    logic sink_valid, sink_sop, sink_eop, busy, frame_done, overflow;
    logic [DW-1:0] sink_real, sink_imag;
    logic [15:0] frame_count, drop_count;

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .DATA_WIDTH (DW), .N_POINTS (NP), .CNT_W (CW), .FIFO_DEPTH (DEPTH), .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk), .reset (reset), .enable (enable), .continuous (continuous), .start (start),
        .smp_data (smp_data), .smp_valid (smp_valid), .sink_ready (sink_ready),
        .sink_valid (sink_valid), .sink_sop (sink_sop), .sink_eop (sink_eop),
        .sink_real (sink_real), .sink_imag (sink_imag), .busy (busy), .frame_done (frame_done),
        .overflow (overflow), .clear_status (clear_status), .frame_count (frame_count),
        .drop_count (drop_count)
    );

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: mode 0 idle, 1 streaming, 2 gap; the queue holds the buffered samples.
    int m_mode = 0, m_beat = 0, m_gap = 0, m_frames = 0, m_drops = 0;
    bit m_done = 0, m_ovf = 0;
    logic [DW-1:0] m_q[$];

    always @(posedge clk) begin
        bit acc;
        acc = (m_mode == 1) && (m_q.size() > 0) && sink_ready;
        if (reset) begin
            m_mode = 0; m_beat = 0; m_gap = 0; m_frames = 0; m_drops = 0;
            m_done = 0; m_ovf = 0; m_q.delete();
        end else begin
            m_done = 0;
            if (clear_status) begin m_ovf = 0; m_frames = 0; m_drops = 0; end
            if (acc) void'(m_q.pop_front());
            if (m_mode == 1 && smp_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(smp_data);
                else begin m_ovf = 1; if (m_drops < 65535) m_drops++; end
            end
            case (m_mode)
                0: if (enable && (start || continuous)) m_mode = 1;
                1: if (acc) begin
                       if (m_beat == NP - 1) begin
                           m_beat = 0; m_q.delete(); m_done = 1;
                           m_frames = (m_frames + 1) % 65536; m_mode = 2; m_gap = 0;
                       end else m_beat++;
                   end
                default: begin
                    m_gap++;
                    if (m_gap == GAP) m_mode = (enable && continuous) ? 1 : 0;
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [63:0] act_v, exp_v;
        logic [DW-1:0] e_real;
        bit e_valid;
        e_valid = (m_mode == 1) && (m_q.size() > 0);
        e_real  = e_valid ? m_q[0] : '0;
        exp_v = {2'b00, e_valid, e_valid && m_beat == 0, e_valid && m_beat == NP - 1,
                 m_mode != 0, m_done, m_ovf, 12'h000, e_real,
                 STATS ? 16'(m_frames) : 16'h0, STATS ? 16'(m_drops) : 16'h0};
        act_v = {2'b00, sink_valid, sink_sop, sink_eop, busy, frame_done, overflow, sink_imag,
                 sink_valid ? sink_real : 12'h000, frame_count, drop_count};
        chk("cycle_vs_model", act_v, exp_v);
    end

    // Observation counters used by the hand-computed scenario checks.
    int cyc = 0, mon_beats = 0, mon_sops = 0, mon_eops = 0, mon_dones = 0, eop_cyc = 0, gap_cyc = 0;
    logic [DW-1:0] sop_data, eop_data, gap_dat;

    always @(negedge clk) begin
        cyc++;
        if (sink_valid && sink_ready) begin
            mon_beats++;
            if (sink_sop) begin
                mon_sops++; sop_data = sink_real;
                if (mon_eops > 0) begin gap_cyc = cyc - eop_cyc; gap_dat = sink_real - eop_data; end
            end
            if (sink_eop) begin mon_eops++; eop_data = sink_real; eop_cyc = cyc; end
        end
        if (frame_done) mon_dones++;
    end

    task automatic mon_clear();
        mon_beats = 0; mon_sops = 0; mon_eops = 0; mon_dones = 0;
    endtask

    int unsigned ramp = 0;
    task automatic tick();
        @(posedge clk); #1;
        ramp++;
        smp_data = DW'(ramp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    logic [DW-1:0] r0, held;
    bit stable;

    initial begin
        reset = 1; enable = 0; continuous = 0; start = 0; smp_valid = 0; sink_ready = 1;
        clear_status = 0; smp_data = '0;
        repeat (3) tick();
        chk("reset_valid", sink_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_real", sink_real, 0);
        reset = 0;

        // Single-shot frame, full throughput.
        enable = 1; smp_valid = 1; mon_clear();
        start = 1; r0 = smp_data; tick(); start = 0;
        repeat (40) tick();
        chk("t1_beats", mon_beats, NP);
        chk("t1_sops", mon_sops, 1);
        chk("t1_eops", mon_eops, 1);
        chk("t1_frame_done_pulses", mon_dones, 1);
        chk("t1_sop_data", sop_data, DW'(r0 + 1));
        chk("t1_contiguous", DW'(eop_data - sop_data), NP - 1);
        chk("t1_idle_after", busy, 0);
        chk("t1_frame_count", frame_count, STATS ? 1 : 0);

        // Continuous capture; enable dropped at beat 5 of the second frame.
        clear_status = 1; tick(); clear_status = 0;
        mon_clear(); continuous = 1;
        for (int k = 0; k < 200 && mon_beats < NP + 5; k++) tick();
        chk("t2_reach_beat5", mon_beats, NP + 5);
        enable = 0;
        chk("t2_gap_cycles_ge", (gap_cyc >= GAP) ? 1 : 0, 1);
        chk("t2_fresh_samples", (gap_dat >= DW'(GAP + 1)) ? 1 : 0, 1);
        for (int k = 0; k < 100 && mon_eops < 2; k++) tick();
        chk("t2_frame_completed", mon_beats, 2 * NP);
        repeat (GAP + 2) tick();
        chk("t2_busy_fell", busy, 0);
        repeat (20) tick();
        chk("t2_no_new_frame", mon_sops, 2);
        continuous = 0; enable = 1;

        // Backpressure stall with an empty buffer at stall start: 4 samples fit, 6 drop.
        smp_valid = 0; clear_status = 1; tick(); clear_status = 0;
        mon_clear(); start = 1; tick(); start = 0;
        smp_valid = 1; repeat (5) tick();
        smp_valid = 0; tick();
        sink_ready = 0; smp_valid = 1; stable = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) held = sink_real;
            if (i > 1 && (!sink_valid || sink_real != held)) stable = 0;
            tick();
        end
        chk("t3_data_held", stable, 1);
        chk("t3_overflow", overflow, 1);
        chk("t3_drop_count", drop_count, STATS ? 6 : 0);
        sink_ready = 1;
        for (int k = 0; k < 100 && mon_eops < 1; k++) tick();
        chk("t3_frame_completed", mon_beats, NP);
        repeat (GAP + 2) tick();

        // Reset mid-frame at beat 7, then a fresh frame.
        mon_clear(); start = 1; tick(); start = 0;
        for (int k = 0; k < 50 && mon_beats < 7; k++) tick();
        reset = 1; tick(); reset = 0;
        chk("t4_zero_outputs", {sink_valid, sink_sop, sink_eop, busy, frame_done, overflow,
                                frame_count, drop_count, sink_real}, 0);
        mon_clear(); start = 1; r0 = smp_data; tick(); start = 0;
        for (int k = 0; k < 50 && mon_sops < 1; k++) tick();
        chk("t4_sop_fresh", sop_data, DW'(r0 + 1));
        for (int k = 0; k < 50 && mon_eops < 1; k++) tick();
        repeat (GAP + 2) tick();

        // clear_status on the same cycle as a drop.
        mon_clear(); sink_ready = 0; start = 1; tick(); start = 0;
        repeat (8) tick();
        clear_status = 1; tick(); clear_status = 0;
        chk("t5_overflow", overflow, 1);
        chk("t5_drop_count", drop_count, STATS ? 1 : 0);
        sink_ready = 1;
        for (int k = 0; k < 100 && mon_eops < 1; k++) tick();
        chk("t5_frame_completed", mon_eops, 1);
        repeat (GAP + 2) tick();

        // Randomised traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            enable       = ($urandom_range(0, 19) != 0);
            start        = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) continuous = !continuous;
            smp_valid    = ($urandom_range(0, 9) < 7);
            sink_ready   = ($urandom_range(0, 9) < 6);
            clear_status = ($urandom_range(0, 49) == 0);
            reset        = ($urandom_range(0, 999) == 0);
            smp_data     = DW'($urandom);
            tick();
        end
        reset = 0; start = 0; clear_status = 0;
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
